// File: rtl/input_controller_if.sv
// Player-button / command bus between the button front end and the game-state block.
interface input_controller_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_rot;
  logic       btn_down;
  logic       btn_start;
  logic       busy;
  logic [2:0] operation;
  logic       pending;

  modport master (
    output btn_left, btn_right, btn_rot, btn_down, btn_start, busy,
    input  operation, pending
  );

  modport slave (
    input  btn_left, btn_right, btn_rot, btn_down, btn_start, busy,
    output operation, pending
  );
endinterface

// File: rtl/input_controller.sv
// input_controller: synchronises, debounces and edge-detects five player buttons,
// resolves same-cycle priority and holds one pending command while downstream is busy.
// Optional auto-repeat for left/right/down is compiled in with INPUT_AUTOREPEAT_EN.
module input_controller #(
  parameter int unsigned DB_COUNT     = 4,
  parameter int unsigned REPEAT_DELAY = 12,
  parameter int unsigned REPEAT_RATE  = 4,
  parameter int unsigned CNT_W        = 5
) (
  input logic              clk,
  input logic              rst_n,
  input_controller_if.slave bus
);

  localparam int unsigned NB      = 5;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // Button bit positions inside the packed vectors below.
  localparam int unsigned I_LEFT  = 0;
  localparam int unsigned I_RIGHT = 1;
  localparam int unsigned I_ROT   = 2;
  localparam int unsigned I_DOWN  = 3;
  localparam int unsigned I_START = 4;

  localparam logic [2:0] OP_IDLE  = 3'd0;
  localparam logic [2:0] OP_LEFT  = 3'd1;
  localparam logic [2:0] OP_RIGHT = 3'd2;
  localparam logic [2:0] OP_ROT   = 3'd3;
  localparam logic [2:0] OP_START = 3'd4;
  localparam logic [2:0] OP_DOWN  = 3'd5;

  // Elaboration-time guard on the parameter set.
  if (DB_COUNT < 2 || REPEAT_RATE < 1 || DB_COUNT > CNT_MAX ||
      REPEAT_DELAY > CNT_MAX || REPEAT_RATE > CNT_MAX) begin : g_param_check
    $error("input_controller: illegal parameter combination");
  end

  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1, sync2, stable, stable_d;
  logic [CNT_W-1:0] db_cnt [NB];
  logic [NB-1:0]    press, events;
  logic [2:0]       ev_op;
  logic             slot_v, slot_v_n;
  logic [2:0]       slot_op, slot_op_n;
  logic [2:0]       op_q, op_n;
  logic             blocked;

  assign raw = {bus.btn_start, bus.btn_down, bus.btn_rot, bus.btn_right, bus.btn_left};

  // Higher value wins when events collide or compete for the slot.
  function automatic logic [2:0] rank(input logic [2:0] op);
    case (op)
      OP_START: rank = 3'd5;
      OP_ROT:   rank = 3'd4;
      OP_LEFT:  rank = 3'd3;
      OP_RIGHT: rank = 3'd2;
      OP_DOWN:  rank = 3'd1;
      default:  rank = 3'd0;
    endcase
  endfunction

  // Two-flop synchroniser plus debouncer; the counter never passes DB_COUNT-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] >= CNT_W'(DB_COUNT - 1)) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = stable & ~stable_d;

`ifdef INPUT_AUTOREPEAT_EN
  localparam logic [NB-1:0] REP_MASK = NB'((1 << I_LEFT) | (1 << I_RIGHT) | (1 << I_DOWN));

  logic [CNT_W-1:0] rep_cnt [NB];
  logic [NB-1:0]    rep_phase;
  logic [NB-1:0]    rep_fire;

  // Repeat fires DELAY cycles after the press, then every RATE cycles while held.
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < NB; i++) begin
      if (REP_MASK[i] && stable[i] && rep_cnt[i] != '0) begin
        rep_fire[i] = rep_phase[i] ? (rep_cnt[i] == CNT_W'(REPEAT_RATE))
                                   : (rep_cnt[i] == CNT_W'(REPEAT_DELAY));
      end
    end
  end

  // Repeat counters: started by a press, restarted by each repeat, cleared on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_phase <= '0;
      for (int i = 0; i < NB; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (!REP_MASK[i] || !stable[i]) begin
          rep_cnt[i]   <= '0;
          rep_phase[i] <= 1'b0;
        end else if (press[i]) begin
          rep_cnt[i]   <= CNT_W'(1);
          rep_phase[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          rep_cnt[i]   <= CNT_W'(1);
          rep_phase[i] <= 1'b1;
        end else if (rep_cnt[i] != '0 && rep_cnt[i] != '1) begin
          rep_cnt[i]   <= rep_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign events = press | rep_fire;
`else
  assign events = press;
`endif

  // Fixed priority: start > rotate > left > right > down.
  always_comb begin
    ev_op = OP_IDLE;
    if      (events[I_START]) ev_op = OP_START;
    else if (events[I_ROT])   ev_op = OP_ROT;
    else if (events[I_LEFT])  ev_op = OP_LEFT;
    else if (events[I_RIGHT]) ev_op = OP_RIGHT;
    else if (events[I_DOWN])  ev_op = OP_DOWN;
  end

  // No issue while downstream is busy or in the cycle right after an issue.
  assign blocked = bus.busy | (op_q != OP_IDLE);

  // Pending slot next state.
  always_comb begin
    slot_v_n  = slot_v;
    slot_op_n = slot_op;
    if (!blocked) begin
      if (slot_v) begin
        slot_v_n  = (ev_op != OP_IDLE);
        slot_op_n = ev_op;
      end
    end else if (ev_op != OP_IDLE && (!slot_v || rank(ev_op) > rank(slot_op))) begin
      slot_v_n  = 1'b1;
      slot_op_n = ev_op;
    end
  end

  // Command to issue this cycle: the held one first, else a fresh event.
  always_comb begin
    op_n = OP_IDLE;
    if (!blocked) op_n = slot_v ? slot_op : ev_op;
  end

  // Slot and command registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_v  <= 1'b0;
      slot_op <= OP_IDLE;
      op_q    <= OP_IDLE;
    end else begin
      slot_v  <= slot_v_n;
      slot_op <= slot_op_n;
      op_q    <= op_n;
    end
  end

  assign bus.operation = op_q;
  assign bus.pending   = slot_v;

endmodule

// File: tb/tb_input_controller.sv
// Bench for input_controller: directed scenarios with literal expectations plus
// randomized buttons/busy/reset checked every cycle against a behavioural model.
module tb_input_controller;

  localparam int unsigned DB = 4;
  localparam int unsigned RD = 12;
  localparam int unsigned RR = 4;
  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  logic rst_n;

  input_controller_if bus();

  input_controller #(
    .DB_COUNT(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state (button order: left, right, rot, down, start).
  bit [4:0] r1, r2, m_stable, m_rose, m_held;
  int       m_run   [5];
  int       m_press [5];
  bit       m_slot_v;
  int       m_slot_op;
  int       m_last;
  int       exp_op;
  bit       exp_pend;
  bit       started = 1'b0;
  int       prev_op = 0;

  int log_cyc[$];
  int log_op[$];

  function automatic int code_of(input int i);
    case (i)
      0: code_of = 1;
      1: code_of = 2;
      2: code_of = 3;
      3: code_of = 5;
      default: code_of = 4;
    endcase
  endfunction

  function automatic int rank_of(input int op);
    case (op)
      4: rank_of = 5;
      3: rank_of = 4;
      1: rank_of = 3;
      2: rank_of = 2;
      5: rank_of = 1;
      default: rank_of = 0;
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic set_btns(input bit [4:0] b);
    bus.btn_left  = b[0];
    bus.btn_right = b[1];
    bus.btn_rot   = b[2];
    bus.btn_down  = b[3];
    bus.btn_start = b[4];
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    log_cyc.delete();
    log_op.delete();
  endtask

  // Reference model: evaluated at every rising edge from the inputs seen at that edge.
  always @(posedge clk) begin
    bit [4:0] raw;
    bit       ev;
    bit       blocked;
    int       best;
    int       k;
    int       nop;
    cyc++;
    raw = {bus.btn_start, bus.btn_down, bus.btn_rot, bus.btn_right, bus.btn_left};
    if (!rst_n) begin
      started   = 1'b1;
      r1 = '0; r2 = '0; m_stable = '0; m_rose = '0; m_held = '0;
      for (int i = 0; i < 5; i++) begin m_run[i] = 0; m_press[i] = 0; end
      m_slot_v  = 1'b0;
      m_slot_op = 0;
      m_last    = 0;
      exp_op    = 0;
      exp_pend  = 1'b0;
    end else begin
      best = 0;
      for (int i = 0; i < 5; i++) begin
        if (!m_stable[i]) m_held[i] = 1'b0;
        ev = m_rose[i];
`ifdef INPUT_AUTOREPEAT_EN
        if (i != 2 && i != 4 && m_held[i]) begin
          k = cyc - m_press[i];
          if (k >= int'(RD) && ((k - int'(RD)) % int'(RR)) == 0) ev = 1'b1;
        end
`endif
        if (m_rose[i]) begin
          m_press[i] = cyc;
          m_held[i]  = 1'b1;
        end
        if (ev && rank_of(code_of(i)) > rank_of(best)) best = code_of(i);
      end
      blocked = bus.busy || (m_last != 0);
      nop = 0;
      if (!blocked) begin
        if (m_slot_v) begin
          nop       = m_slot_op;
          m_slot_v  = (best != 0);
          m_slot_op = best;
        end else begin
          nop = best;
        end
      end else if (best != 0 && (!m_slot_v || rank_of(best) > rank_of(m_slot_op))) begin
        m_slot_v  = 1'b1;
        m_slot_op = best;
      end
      m_last   = nop;
      exp_op   = nop;
      exp_pend = m_slot_v;
      // Debounced level flips after DB consecutive synchronised samples disagree with it.
      for (int i = 0; i < 5; i++) begin
        m_rose[i] = 1'b0;
        if (r2[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(DB)) begin
            m_stable[i] = r2[i];
            m_rose[i]   = r2[i];
            m_run[i]    = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      r2 = r1;
      r1 = raw;
    end
  end

  // Compare DUT against the model every cycle and log every issued command.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (bus.operation !== 3'(exp_op)) begin
        errors++;
        $display("FAIL model_op: got %0d expected %0d (cycle %0d)", bus.operation, exp_op, cyc);
      end
      checks++;
      if (bus.pending !== exp_pend) begin
        errors++;
        $display("FAIL model_pending: got %0d expected %0d (cycle %0d)", bus.pending, exp_pend, cyc);
      end
      if (bus.operation != 3'd0) begin
        checks++;
        if (prev_op != 0) begin
          errors++;
          $display("FAIL back_to_back: got %0d after %0d (cycle %0d)", bus.operation, prev_op, cyc);
        end
        log_cyc.push_back(cyc);
        log_op.push_back(int'(bus.operation));
      end
      prev_op = int'(bus.operation);
    end
  end

  int t;
  int n4;
  int exp_off[$];
  int hold_cnt[5];
  bit [4:0] lvl;
  int rst_hold;

  initial begin
    rst_n    = 1'b0;
    bus.busy = 1'b0;
    set_btns(5'b11111);

    // Reset with every button held: outputs stay quiet.
    repeat (3) begin
      @(negedge clk);
      chk("reset_op", int'(bus.operation), 0);
      chk("reset_pending", int'(bus.pending), 0);
    end
    rst_n = 1'b1;
    t = cyc + 1;
    clear_log();
    tick(20);
    n4 = 0;
    foreach (log_op[j]) if (log_op[j] == 4) n4++;
    chk("reset_start_count", n4, 1);
    if (log_op.size() > 0) begin
      chk("reset_first_code", log_op[0], 4);
      chk("reset_first_latency", log_cyc[0] - t, 6);
    end else begin
      chk("reset_first_present", 0, 1);
    end
    set_btns(5'b00000);
    tick(15);
    clear_log();

    // Bouncing left button settles high: one command 6 cycles after the last rise.
    bus.btn_left = 1'b1; tick(1);
    bus.btn_left = 1'b0; tick(1);
    bus.btn_left = 1'b1; tick(1);
    bus.btn_left = 1'b0; tick(1);
    bus.btn_left = 1'b1;
    t = cyc + 1;
    tick(8);
    bus.btn_left = 1'b0;
    tick(15);
    chk("bounce_count", log_op.size(), 1);
    if (log_op.size() > 0) begin
      chk("bounce_code", log_op[0], 1);
      chk("bounce_latency", log_cyc[0] - t, 6);
    end
    clear_log();

    // A 3-cycle pulse is rejected.
    bus.btn_left = 1'b1; tick(3);
    bus.btn_left = 1'b0; tick(20);
    chk("glitch_count", log_op.size(), 0);
    clear_log();

    // Rotate and right on the same edge: rotate only.
    bus.btn_rot = 1'b1; bus.btn_right = 1'b1;
    tick(8);
    bus.btn_rot = 1'b0; bus.btn_right = 1'b0;
    tick(15);
    chk("priority_count", log_op.size(), 1);
    if (log_op.size() > 0) chk("priority_code", log_op[0], 3);
    clear_log();

    // Busy hold: down then start while busy; start replaces down in the slot.
    bus.busy = 1'b1;
    bus.btn_down = 1'b1; tick(6);
    bus.btn_down = 1'b0; tick(4);
    bus.btn_start = 1'b1; tick(6);
    bus.btn_start = 1'b0; tick(6);
    chk("busy_pending", int'(bus.pending), 1);
    chk("busy_no_issue", log_op.size(), 0);
    bus.busy = 1'b0;
    t = cyc + 1;
    tick(10);
    chk("busy_count", log_op.size(), 1);
    if (log_op.size() > 0) begin
      chk("busy_code", log_op[0], 4);
      chk("busy_latency", log_cyc[0] - t, 0);
    end
    chk("busy_pending_clear", int'(bus.pending), 0);
    clear_log();

    // Held right button: press plus auto-repeats when compiled in.
    bus.btn_right = 1'b1;
    t = cyc + 1;
    tick(32);
    bus.btn_right = 1'b0;
    tick(15);
    exp_off.delete();
    exp_off.push_back(0);
`ifdef INPUT_AUTOREPEAT_EN
    exp_off.push_back(12);
    exp_off.push_back(16);
    exp_off.push_back(20);
    exp_off.push_back(24);
    exp_off.push_back(28);
`endif
    chk("repeat_count", log_op.size(), exp_off.size());
    for (int j = 0; j < exp_off.size() && j < log_op.size(); j++) begin
      chk("repeat_code", log_op[j], 2);
      chk("repeat_time", log_cyc[j] - (t + 6), exp_off[j]);
    end
    clear_log();

    // Randomized buttons, busy and occasional reset against the model.
    for (int i = 0; i < 5; i++) hold_cnt[i] = 0;
    lvl = '0;
    rst_hold = 0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        if (hold_cnt[i] == 0) begin
          lvl[i] = ~lvl[i];
          hold_cnt[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                    : int'($urandom_range(4, 40));
        end else begin
          hold_cnt[i]--;
        end
      end
      set_btns(lvl);
      if ($urandom_range(0, 7) == 0) bus.busy = ~bus.busy;
      if (rst_hold > 0) begin
        rst_hold--;
        rst_n = (rst_hold == 0);
      end else if ($urandom_range(0, 599) == 0) begin
        rst_hold = int'($urandom_range(1, 3));
        rst_n = 1'b0;
      end
    end
    rst_n = 1'b1;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
